// File: rtl/uart_string_tx_arbiter.sv
// Round-robin arbiter sharing one UART string transmitter among N_REQ requesters.
// Latches the winner's string/length, rejects bad lengths and aborts on a stalled transmitter.
module uart_string_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned STR_W       = 1096,
    parameter int unsigned MAX_LEN     = 137,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*STR_W-1:0]   req_string,
    input  logic [N_REQ*8-1:0]       req_length,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         err,
    output logic                     busy,
    output logic [STR_W-1:0]         tx_string,
    output logic [7:0]               tx_length,
    output logic                     tx_req,
    input  logic                     tx_busy,
    input  logic                     tx_done
);
    localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] win_idx;
    logic             err_flag;
    logic [31:0]      wd_cnt;

    logic             rr_found_c;
    logic [IDX_W-1:0] rr_idx_c;
    logic [IDX_W-1:0] rr_pos_c;
    logic [STR_W-1:0] sel_string_c;
    logic [7:0]       sel_length_c;
    logic             sel_bad_c;

    // Round-robin search starting one past the last served requester
    always_comb begin
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        rr_pos_c   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            rr_pos_c = IDX_W'((32'(last_idx) + k) % N_REQ);
            if (!rr_found_c && req[rr_pos_c]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = rr_pos_c;
            end
        end
    end

    // Winner's payload slices and length legality
    always_comb begin
        sel_string_c = '0;
        sel_length_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_string_c = req_string[i*STR_W +: STR_W];
                sel_length_c = req_length[i*8 +: 8];
            end
        end
        sel_bad_c = (sel_length_c == 8'd0) || (32'(sel_length_c) > MAX_LEN);
    end

    // Arbiter FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            last_idx  <= IDX_W'(N_REQ - 1);
            win_idx   <= '0;
            err_flag  <= 1'b0;
            wd_cnt    <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            tx_string <= '0;
            tx_length <= '0;
            tx_req    <= 1'b0;
        end else begin
            tx_req <= 1'b0;
            done   <= '0;
            err    <= '0;
            case (state)
                S_IDLE: begin
                    if (rr_found_c) begin
                        grant   <= ONE_HOT0 << rr_idx_c;
                        win_idx <= rr_idx_c;
                        busy    <= 1'b1;
                        state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    tx_string <= sel_string_c;
                    tx_length <= sel_length_c;
                    err_flag  <= sel_bad_c;
                    state     <= sel_bad_c ? S_DONE : S_LAUNCH;
                end
                S_LAUNCH: begin
                    if (!tx_busy) begin
                        tx_req <= 1'b1;
                        wd_cnt <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    // A completion in the same cycle as the watchdog expiry counts as success
                    if (tx_done) begin
                        err_flag <= 1'b0;
                        state    <= S_DONE;
                    end else if (wd_cnt == TMO_LAST) begin
                        err_flag <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done[win_idx] <= 1'b1;
                    err[win_idx]  <= err_flag;
                    last_idx      <= win_idx;
                    grant         <= '0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_string_tx_arbiter.sv
// Self-checking bench: directed scenarios plus randomized request mixes against a
// round-robin / latency reference model of the arbiter.
module tb_uart_string_tx_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 1096;
    localparam int unsigned ML = 137;
    localparam int unsigned TO = 1000;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [N-1:0]      req;
    logic [N*SW-1:0]   req_string;
    logic [N*8-1:0]    req_length;
    logic [N-1:0]      grant, done, err;
    logic              busy, tx_req, tx_busy, tx_done;
    logic [SW-1:0]     tx_string;
    logic [7:0]        tx_length;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txreq_cnt = 0;
    bit auto_resp = 1'b0;
    int resp_delay = 1;
    int done_at = -1;
    int model_last = int'(N) - 1;
    logic [7:0]    src_len [N];
    logic [SW-1:0] src_str [N];

    uart_string_tx_arbiter #(
        .N_REQ(N), .STR_W(SW), .MAX_LEN(ML), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req),
        .req_string(req_string), .req_length(req_length),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .tx_string(tx_string), .tx_length(tx_length), .tx_req(tx_req),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed low128 %0h expected low128 %0h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " grant"},  32'(grant), 32'd0);
        chk({tag, " done"},   32'(done),  32'd0);
        chk({tag, " err"},    32'(err),   32'd0);
        chk({tag, " busy"},   32'(busy),  32'd0);
        chk({tag, " tx_req"}, 32'(tx_req), 32'd0);
        chk({tag, " tx_length"}, 32'(tx_length), 32'd0);
        chk_str({tag, " tx_string"}, tx_string, '0);
    endtask

    // One clock; also plays the transmitter when auto_resp is set
    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (tx_req === 1'b1) begin
            txreq_cnt++;
            if (auto_resp) done_at = cyc + resp_delay;
        end
        tx_done = auto_resp && (cyc == done_at);
    endtask

    function automatic logic [SW-1:0] str_of(input string s);
        logic [SW-1:0] v = '0;
        for (int k = 0; k < s.len(); k++) v[8*k +: 8] = s[k];
        return v;
    endfunction

    function automatic logic [SW-1:0] rand_str();
        logic [SW-1:0] v = '0;
        for (int k = 0; k < int'(SW / 8); k++) v[8*k +: 8] = 8'($urandom_range(32, 126));
        return v;
    endfunction

    function automatic logic [7:0] rand_len(input bit allow_bad);
        if (allow_bad && $urandom_range(0, 3) == 0)
            return ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(ML + 1, 255));
        return 8'($urandom_range(1, ML));
    endfunction

    task automatic set_src(input int i, input logic [7:0] len, input logic [SW-1:0] s);
        src_len[i] = len;
        src_str[i] = s;
        req_length[i*8 +: 8]   = len;
        req_string[i*SW +: SW] = s;
    endtask

    // Round-robin reference: first requesting index after the last served one
    function automatic int rr_pick(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= int'(N); k++) begin
            int idx = (last + k) % int'(N);
            if (((m >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    task automatic wait_done(input int budget, output logic [N-1:0] g, output logic [N-1:0] d,
                             output logic [N-1:0] e, output int nreq, output int t_req,
                             output int t_done);
        int n0 = txreq_cnt;
        g = '0; d = '0; e = '0; t_req = -1; t_done = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (g == '0 && grant != '0) g = grant;
            if (tx_req === 1'b1) t_req = cyc;
            if (done !== '0) begin
                d = done; e = err; t_done = cyc;
                break;
            end
        end
        nreq = txreq_cnt - n0;
        checks++;
        assert (t_done >= 0) else begin
            errors++;
            $error("FAIL wait_done: observed no done, expected one within %0d cycles", budget);
        end
    endtask

    // Serve requester w; delay < 0 means the transmitter never completes
    task automatic expect_service(input string tag, input int w, input int delay, input bit drop,
                                  output int t_req);
        logic [N-1:0] g, d, e;
        int nr, td, lat;
        bit bad, fail_err, stalls;
        bad      = (src_len[w] == 8'd0) || (32'(src_len[w]) > ML);
        stalls   = (delay < 0) || (delay >= int'(TO));
        fail_err = bad || stalls;
        lat      = stalls ? int'(TO) + 1 : delay + 2;
        auto_resp  = (delay >= 0);
        resp_delay = delay;
        wait_done(2 * int'(TO) + 100, g, d, e, nr, t_req, td);
        if (drop) req = req & ~(N'(1) << w);
        chk({tag, " grant"}, 32'(g), 32'(1) << w);
        chk({tag, " done"},  32'(d), 32'(1) << w);
        chk({tag, " err"},   32'(e), fail_err ? (32'(1) << w) : 32'd0);
        chk({tag, " tx_req count"}, 32'(nr), bad ? 32'd0 : 32'd1);
        chk({tag, " tx_length"}, 32'(tx_length), 32'(src_len[w]));
        chk_str({tag, " tx_string"}, tx_string, src_str[w]);
        if (!bad) chk({tag, " latency"}, 32'(td - t_req), 32'(lat));
        model_last = w;
    endtask

    initial begin
        int tq, n0, w, guard;
        logic [N-1:0] pending, newbits;
        logic [SW-1:0] str_a, str_b;
        logic [7:0] rej_len [2];

        sys_rst_n = 1'b0; req = '0; req_string = '0; req_length = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            src_len[i] = '0;
            src_str[i] = '0;
        end
        step(); step();
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        step();

        // Single request, "HELLO"
        set_src(0, 8'd5, str_of("HELLO"));
        req = 4'b0001;
        step();
        chk("hello grant edge0", 32'(grant), 32'h1);
        chk("hello busy", 32'(busy), 32'd1);
        step();
        chk("hello tx_length edge1", 32'(tx_length), 32'd5);
        chk_str("hello tx_string edge1", tx_string, str_of("HELLO"));
        chk("hello tx_req before edge2", 32'(tx_req), 32'd0);
        step();
        chk("hello tx_req edge2", 32'(tx_req), 32'd1);
        repeat (100) step();
        tx_done = 1'b1;
        chk("hello no early done", 32'(done), 32'd0);
        step();
        chk("hello grant held", 32'(grant), 32'h1);
        step();
        chk("hello done", 32'(done), 32'h1);
        chk("hello err", 32'(err), 32'd0);
        chk("hello grant cleared", 32'(grant), 32'd0);
        chk("hello busy cleared", 32'(busy), 32'd0);
        chk("hello tx_req total", 32'(txreq_cnt), 32'd1);
        req = '0;
        model_last = 0;

        // Fairness with all requesters held high
        for (int i = 0; i < int'(N); i++) set_src(i, rand_len(1'b0), rand_str());
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            w = rr_pick(model_last, 4'b1111);
            expect_service($sformatf("fair%0d", t), w, int'($urandom_range(1, 20)), t == 4, tq);
        end

        // Reject: zero and oversize lengths
        rej_len[0] = 8'd0;
        rej_len[1] = 8'd200;
        for (int t = 0; t < 2; t++) begin
            set_src(2, rej_len[t], rand_str());
            n0 = txreq_cnt;
            req = 4'b0100;
            step();
            chk($sformatf("reject%0d grant", t), 32'(grant), 32'h4);
            step();
            chk($sformatf("reject%0d done early", t), 32'(done), 32'd0);
            step();
            chk($sformatf("reject%0d done", t), 32'(done), 32'h4);
            chk($sformatf("reject%0d err", t), 32'(err), 32'h4);
            chk($sformatf("reject%0d no tx_req", t), 32'(txreq_cnt - n0), 32'd0);
            chk($sformatf("reject%0d tx_length", t), 32'(tx_length), 32'(rej_len[t]));
            req = '0;
            model_last = 2;
        end

        // Busy gate: transmitter busy for 50 cycles, requester changes its string after LATCH
        auto_resp = 1'b0;
        str_a = rand_str();
        str_b = ~str_a;
        set_src(1, 8'd40, str_a);
        tx_busy = 1'b1;
        req = 4'b0010;
        n0 = txreq_cnt;
        step();
        chk("busygate grant", 32'(grant), 32'h2);
        step();
        chk_str("busygate latch", tx_string, str_a);
        req_string[1*SW +: SW] = str_b;
        repeat (48) step();
        chk("busygate no tx_req while busy", 32'(txreq_cnt - n0), 32'd0);
        tx_busy = 1'b0;
        step();
        chk("busygate tx_req", 32'(tx_req), 32'd1);
        chk_str("busygate tx_string kept", tx_string, str_a);
        tx_done = 1'b1;
        step(); step();
        chk("busygate done", 32'(done), 32'h2);
        chk("busygate err", 32'(err), 32'd0);
        req = '0;
        model_last = 1;

        // Timeout, then a stray late completion
        set_src(0, rand_len(1'b0), rand_str());
        req = 4'b0001;
        expect_service("timeout", 0, -1, 1'b1, tq);
        while (cyc < tq + 1500) step();
        tx_done = 1'b1;
        n0 = txreq_cnt;
        step();
        chk("late done ignored busy", 32'(busy), 32'd0);
        chk("late done ignored grant", 32'(grant), 32'd0);
        step();
        chk("late done ignored done", 32'(done), 32'd0);
        chk("late done ignored err", 32'(err), 32'd0);
        chk("late done no tx_req", 32'(txreq_cnt - n0), 32'd0);

        // Completion racing the watchdog
        req = 4'b0001;
        expect_service("tie", 0, int'(TO) - 1, 1'b1, tq);
        req = 4'b0001;
        expect_service("one late", 0, int'(TO), 1'b1, tq);

        // Randomized request mixes, arrivals while busy held pending
        pending = '0;
        for (int it = 0; it < 12; it++) begin
            if (pending == '0 || $urandom_range(0, 1) == 1) begin
                newbits = N'($urandom) & ~pending;
                for (int i = 0; i < int'(N); i++)
                    if (newbits[i]) set_src(i, rand_len(1'b1), rand_str());
                pending = pending | newbits;
                req = pending;
            end
            if (pending == '0) continue;
            w = rr_pick(model_last, pending);
            expect_service($sformatf("rand%0d", it), w, int'($urandom_range(1, 30)), 1'b1, tq);
            pending = pending & ~(N'(1) << w);
        end
        guard = 0;
        while (pending != '0 && guard < int'(N)) begin
            w = rr_pick(model_last, pending);
            expect_service("drain", w, int'($urandom_range(1, 30)), 1'b1, tq);
            pending = pending & ~(N'(1) << w);
            guard++;
        end

        // Reset in the middle of WAIT
        auto_resp = 1'b0;
        set_src(0, rand_len(1'b0), rand_str());
        req = 4'b0001;
        repeat (8) step();
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("midwait reset");
        set_src(3, rand_len(1'b0), rand_str());
        req = 4'b1001;
        model_last = int'(N) - 1;
        step(); step();
        sys_rst_n = 1'b1;
        expect_service("post reset first", rr_pick(model_last, 4'b1001), 5, 1'b1, tq);
        expect_service("post reset second", rr_pick(model_last, req), 5, 1'b1, tq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
